// File: rtl/popcount_ternary_acc.sv
// Ternary-neuron accumulator built around popcount.
//
// Each beat carries two N-bit vectors. Bits in input_a have weight +1 and
// bits in input_b have weight -1. The signed difference of their popcounts
// is summed over BEATS beats. The frame sum and a threshold activation bit
// are then presented on the output side.
//
// Flow control:
//   A transfer happens on a rising edge where valid and ready are both high.
//   valid never waits for ready. Once out_valid is raised, out_sum and
//   out_act are held stable until the transfer completes.
//   in_ready depends combinationally on frame_clr, out_valid and out_ready.
//   It never depends on in_valid, so upstream may use it freely.
module popcount_ternary_acc #(
  parameter int N      = 23,
  parameter int BEATS  = 4,
  parameter int THRESH = 0,
  localparam int CW    = $clog2(N + 1),
  localparam int AW    = $clog2(N * BEATS + 1) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         input_a,
  input  logic [N-1:0]         input_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 frame_clr,
  output logic signed [AW-1:0] out_sum,
  output logic                 out_act,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // When BEATS is 1, keep the counter one bit wide so the index never
  // collapses to zero width. Its only legal value is then 0.
  localparam int CNTW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

  // Exact popcount as a ripple of adds. Synthesis rebuilds it as an adder tree.
  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  logic [CW-1:0]        pa;
  logic [CW-1:0]        pb;
  logic signed [AW-1:0] diff;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum_next;
  logic [CNTW-1:0]      cnt;
  logic                 accept;
  logic                 last_beat;

  assign pa = popcount(input_a);
  assign pb = popcount(input_b);

  // Zero-extend both counts before subtracting. AW is always wider than CW,
  // so the subtraction cannot wrap.
  assign diff     = $signed({{(AW-CW){1'b0}}, pa}) - $signed({{(AW-CW){1'b0}}, pb});
  assign sum_next = acc + diff;

  // A held, unconsumed result stalls the input side. An abort stalls it for one cycle.
  assign in_ready  = !frame_clr && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == LAST_BEAT);

  // Partial-frame accumulator and beat counter. Both are cleared by abort and by the last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (frame_clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last_beat) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_next;
        cnt <= cnt + CNTW'(1);
      end
    end
  end

  // Result register. A new result may replace one that is being consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_act   <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept && last_beat) begin
      out_sum   <= sum_next;
      out_act   <= (int'(sum_next) >= THRESH);
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_popcount_ternary_acc.sv
// Directed bench for popcount_ternary_acc (N=23, BEATS=4, THRESH=0).
// A second instance with BEATS=1 covers the case where a result is loaded
// in the same cycle that the previous one is consumed.
module tb_popcount_ternary_acc;

  localparam int N   = 23;
  localparam int AW  = 8;   // $clog2(23*4+1)+1
  localparam int AW1 = 6;   // $clog2(23*1+1)+1

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (BEATS=4) ----------------
  logic [N-1:0]         input_a, input_b;
  logic                 in_valid, in_ready, frame_clr;
  logic signed [AW-1:0] out_sum;
  logic                 out_act, out_valid, out_ready;

  popcount_ternary_acc #(.N(N), .BEATS(4), .THRESH(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .input_a(input_a), .input_b(input_b),
    .in_valid(in_valid), .in_ready(in_ready), .frame_clr(frame_clr),
    .out_sum(out_sum), .out_act(out_act), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // ---------------- single-beat DUT (BEATS=1) ----------------
  logic [N-1:0]          b1_a, b1_b;
  logic                  b1_valid, b1_in_ready, b1_clr;
  logic signed [AW1-1:0] b1_sum;
  logic                  b1_act, b1_out_valid, b1_out_ready;

  popcount_ternary_acc #(.N(N), .BEATS(1), .THRESH(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .input_a(b1_a), .input_b(b1_b),
    .in_valid(b1_valid), .in_ready(b1_in_ready), .frame_clr(b1_clr),
    .out_sum(b1_sum), .out_act(b1_act), .out_valid(b1_out_valid),
    .out_ready(b1_out_ready)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected frame sums in completion order.
  logic [AW-1:0] exp_q[$];

  // Monitor: checks every result as it is consumed (out_valid && out_ready).
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        logic signed [AW-1:0] e;
        e = exp_q.pop_front();
        check("sb_sum", int'(out_sum), int'(e));
        check("sb_act", int'(out_act), (e >= 0) ? 1 : 0);
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [N-1:0] ones(input int k);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (i < k) v[i] = 1'b1;
    return v;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic beat_raw(input logic [N-1:0] a, input logic [N-1:0] b);
    int n;
    input_a  = a;
    input_b  = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic beat(input int pa, input int pb);
    beat_raw(ones(pa), ones(pb));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_last;
    int t_now;
    logic [N-1:0] r;

    rst_n        = 1'b0;
    in_valid     = 1'b1;
    input_a      = N'($urandom);
    input_b      = N'($urandom);
    frame_clr    = 1'b0;
    out_ready    = 1'b1;
    b1_a         = '0;
    b1_b         = '0;
    b1_valid     = 1'b0;
    b1_clr       = 1'b0;
    b1_out_ready = 1'b0;

    // 1. Reset held for several cycles while random beats are offered.
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sum", int'(out_sum), 0);
      check("rst_out_act", int'(out_act), 0);
      input_a = N'($urandom);
      input_b = N'($urandom);
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    // The following frame must contain only its own beats: 4 * (3-1) = 8.
    exp_q.push_back(AW'(8));
    repeat (4) beat(3, 1);
    check("post_rst_sum", int'(out_sum), 8);
    check("post_rst_valid", int'(out_valid), 1);

    // 2. Extremes.
    exp_q.push_back(AW'(92));
    beat(N, 0); beat(N, 0); beat(N, 0);
    check("pos_not_yet_valid", int'(out_valid), 0);
    beat(N, 0);
    check("pos_valid", int'(out_valid), 1);
    check("pos_sum", int'(out_sum), 92);
    check("pos_act", int'(out_act), 1);
    exp_q.push_back(AW'(-92));
    repeat (4) beat(0, N);
    check("neg_sum", int'(out_sum), -92);
    check("neg_act", int'(out_act), 0);

    // 3. Threshold boundary: 2 - 2 + 0 + 0 = 0, then 2 - 2 + 0 - 1 = -1.
    exp_q.push_back(AW'(0));
    beat(5, 3); beat(2, 4); beat(7, 7); beat(0, 0);
    check("thr_zero_sum", int'(out_sum), 0);
    check("thr_zero_act", int'(out_act), 1);
    exp_q.push_back(AW'(-1));
    beat(5, 3); beat(2, 4); beat(7, 7); beat(0, 1);
    check("thr_m1_sum", int'(out_sum), -1);
    check("thr_m1_act", int'(out_act), 0);
    idle(1);

    // 4. Backpressure: a frame with sum 8, then 5 stalled cycles.
    out_ready = 1'b0;
    exp_q.push_back(AW'(8));
    repeat (4) beat(2, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      input_a = N'($urandom);
      input_b = N'($urandom);
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_sum_stable", int'(out_sum), 8);
      check("bp_valid_held", int'(out_valid), 1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handshake_done", int'(out_valid), 0);
    exp_q.push_back(AW'(3));
    beat(3, 0); beat(0, 0); beat(0, 0); beat(0, 0);
    check("bp_next_frame_sum", int'(out_sum), 3);
    idle(1);

    // 5. Abort a partial frame.
    beat(10, 0); beat(10, 0);
    frame_clr = 1'b1;
    in_valid  = 1'b1;
    input_a   = ones(N);
    input_b   = '0;
    @(negedge clk);
    check("clr_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    frame_clr = 1'b0;
    in_valid  = 1'b0;
    exp_q.push_back(AW'(4));
    repeat (4) beat(1, 0);
    check("clr_sum", int'(out_sum), 4);
    idle(1);

    // 6. Back-to-back frames: 23, -23, 0. One result every 4 cycles.
    exp_q.push_back(AW'(23));
    exp_q.push_back(AW'(-23));
    exp_q.push_back(AW'(0));
    t_last = 0;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin
        r = N'($urandom);
        if (b == 0 && f == 0)      beat_raw(ones(N), '0);
        else if (b == 0 && f == 1) beat_raw('0, ones(N));
        else                       beat_raw(r, r);
      end
      t_now = cyc;
      check("b2b_valid", int'(out_valid), 1);
      check("b2b_sum", int'(out_sum), (f == 0) ? 23 : ((f == 1) ? -23 : 0));
      if (f > 0) check("b2b_spacing", t_now - t_last, 4);
      t_last = t_now;
    end
    idle(2);

    // BEATS=1: load a new result in the same cycle the held one is consumed.
    b1_a     = ones(3);
    b1_b     = '0;
    b1_valid = 1'b1;
    @(posedge clk); #1;
    b1_a = ones(9);
    @(negedge clk);
    check("b1_first_valid", int'(b1_out_valid), 1);
    check("b1_first_sum", int'(b1_sum), 3);
    check("b1_stall_in_ready", int'(b1_in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b1_sum_held", int'(b1_sum), 3);
    @(posedge clk); #1;
    b1_a         = '0;
    b1_b         = ones(5);
    b1_out_ready = 1'b1;
    @(negedge clk);
    check("b1_swap_in_ready", int'(b1_in_ready), 1);
    @(posedge clk); #1;
    b1_valid = 1'b0;
    @(negedge clk);
    check("b1_swap_valid", int'(b1_out_valid), 1);
    check("b1_swap_sum", int'(b1_sum), -5);
    check("b1_swap_act", int'(b1_act), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b1_drained", int'(b1_out_valid), 0);

    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
